// File: rtl/regfile_issue.sv
// Decode/issue stage: decodes RISC-V fields, reads operands from the register
// file with writeback bypass, tracks in-flight destinations and stalls on hazards.
module regfile_issue #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [6:0]       iss_opcode,
  output logic [AW-1:0]    iss_rd,
  output logic [2:0]       iss_funct3,
  output logic [6:0]       iss_funct7,
  output logic [11:0]      iss_imm12,
  output logic [4:0]       iss_shamt,
  output logic [XLEN-1:0]  iss_rs1_data,
  output logic [XLEN-1:0]  iss_rs2_data,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic [NREGS-1:0] busy_mask
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;

  logic [6:0]    opcode;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic          uses_rs1;
  logic          uses_rs2;
  logic          writes_rd;
  logic          rs1_blocked;
  logic          rs2_blocked;
  logic          rd_blocked;
  logic          hazard;
  logic          slot_free;
  logic          accept;
  logic          wb_live;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign opcode  = in_instr[6:0];
  assign rd      = in_instr[7 +: AW];
  assign rs1     = in_instr[15 +: AW];
  assign rs2     = in_instr[20 +: AW];
  assign wb_live = wb_en && (wb_addr != '0);

  // A pending register is released in the same cycle its writeback arrives,
  // so the stalled instruction issues with the bypassed value.
  always_comb begin
    uses_rs1    = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    uses_rs2    = (opcode == OP_OP || opcode == OP_STORE || opcode == OP_BRANCH);
    writes_rd   = !(opcode == OP_STORE || opcode == OP_BRANCH) && (rd != '0);
    rs1_blocked = uses_rs1 && pending[rs1] && !(wb_en && wb_addr == rs1);
    rs2_blocked = uses_rs2 && pending[rs2] && !(wb_en && wb_addr == rs2);
    rd_blocked  = writes_rd && pending[rd] && !(wb_en && wb_addr == rd);
    hazard      = rs1_blocked || rs2_blocked || rd_blocked;
  end

  always_comb begin
    rs1_val = regs[rs1];
    if (rs1 == '0)                       rs1_val = '0;
    else if (wb_en && wb_addr == rs1)    rs1_val = wb_data;
  end

  always_comb begin
    rs2_val = regs[rs2];
    if (rs2 == '0)                       rs2_val = '0;
    else if (wb_en && wb_addr == rs2)    rs2_val = wb_data;
  end

  // Handshake: a transfer happens on a cycle where valid and ready are both
  // high; in_ready may depend on in_instr, iss_valid must not wait on iss_ready
  // and the packet is held unchanged while iss_valid is high and iss_ready low.
  assign slot_free = !iss_valid || iss_ready;
  assign in_ready  = slot_free && !hazard;
  assign accept    = in_valid && in_ready;
  assign busy_mask = pending;

  // Set after clear so an accept claiming the rd being written back keeps it pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      if (wb_live) begin
        regs[wb_addr]    <= wb_data;
        pending[wb_addr] <= 1'b0;
      end
      if (accept && writes_rd) pending[rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid    <= 1'b0;
      iss_opcode   <= '0;
      iss_rd       <= '0;
      iss_funct3   <= '0;
      iss_funct7   <= '0;
      iss_imm12    <= '0;
      iss_shamt    <= '0;
      iss_rs1_data <= '0;
      iss_rs2_data <= '0;
    end else if (accept) begin
      iss_valid    <= 1'b1;
      iss_opcode   <= opcode;
      iss_rd       <= rd;
      iss_funct3   <= in_instr[14:12];
      iss_funct7   <= in_instr[31:25];
      iss_imm12    <= in_instr[31:20];
      iss_shamt    <= in_instr[24:20];
      iss_rs1_data <= rs1_val;
      iss_rs2_data <= rs2_val;
    end else if (iss_ready) begin
      iss_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_issue.sv
// Bench for regfile_issue: directed scenarios plus randomized traffic checked
// against an array/scoreboard reference model of the issue stage.
module tb_regfile_issue;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             iss_valid;
  logic             iss_ready;
  logic [6:0]       iss_opcode;
  logic [AW-1:0]    iss_rd;
  logic [2:0]       iss_funct3;
  logic [6:0]       iss_funct7;
  logic [11:0]      iss_imm12;
  logic [4:0]       iss_shamt;
  logic [XLEN-1:0]  iss_rs1_data;
  logic [XLEN-1:0]  iss_rs2_data;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic [NREGS-1:0] busy_mask;

  regfile_issue #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode), .iss_rd(iss_rd),
    .iss_funct3(iss_funct3), .iss_funct7(iss_funct7), .iss_imm12(iss_imm12),
    .iss_shamt(iss_shamt), .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy_mask(busy_mask)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model state
  logic [31:0] m_regs [NREGS];
  logic [31:0] m_pend;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_op1;
  logic [31:0] m_op2;
  logic [95:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    return {7'b0, r2, r1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] r1, input logic [11:0] imm);
    return {imm, r1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [4:0] r1, input logic [4:0] r2, input logic [11:0] imm);
    return {imm[11:5], r2, r1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic bit m_writes_rd(input logic [31:0] ins);
    return !(ins[6:0] == 7'b0100011 || ins[6:0] == 7'b1100011) && ins[11:7] != 5'd0;
  endfunction

  function automatic bit m_blocked(input logic [4:0] r);
    return m_pend[r] && !(wb_en && wb_addr == r);
  endfunction

  function automatic bit m_ready();
    logic [6:0] op;
    bit u1, u2, hz;
    op = in_instr[6:0];
    u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    hz = (u1 && m_blocked(in_instr[19:15])) || (u2 && m_blocked(in_instr[24:20])) ||
         (m_writes_rd(in_instr) && m_blocked(in_instr[11:7]));
    return (!m_valid || iss_ready) && !hz;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && wb_addr == r) return wb_data;
    return m_regs[r];
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit acc;
    logic [31:0] o1, o2;
    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_pend = '0; m_valid = 0; m_instr = '0; m_op1 = '0; m_op2 = '0;
    end else begin
      acc = in_valid && m_ready();
      o1 = m_read(in_instr[19:15]);
      o2 = m_read(in_instr[24:20]);
      if (wb_en && wb_addr != 5'd0) begin
        m_regs[wb_addr] = wb_data;
        m_pend[wb_addr] = 1'b0;
      end
      if (acc) begin
        if (m_writes_rd(in_instr)) m_pend[in_instr[11:7]] = 1'b1;
        m_instr = in_instr; m_op1 = o1; m_op2 = o2; m_valid = 1;
      end else if (iss_ready) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 0;
  endtask

  task automatic clear_pending();
    for (int r = 1; r < NREGS; r++)
      if (m_pend[r]) drive_wb(5'(r), 32'(r * 16));
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; in_instr = enc_add(3, 1, 2);
    wb_en = 1; wb_addr = 1; wb_data = 32'd123;
    tick(); tick();
    rst = 0; in_valid = 0; wb_en = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (iss_valid !== 1'b0 || busy_mask !== 32'd0) begin
      errors++; $display("FAIL reset_state: iss_valid=%b busy=%h want 0/0", iss_valid, busy_mask);
    end
    checks++;
    if ({iss_opcode, iss_rd, iss_funct3, iss_funct7, iss_imm12, iss_shamt, iss_rs1_data, iss_rs2_data} !== '0) begin
      errors++; $display("FAIL reset_fields: opcode=%h rd=%0d rs1d=%h rs2d=%h want all 0", iss_opcode, iss_rd, iss_rs1_data, iss_rs2_data);
    end
    in_valid = 1; in_instr = enc_add(3, 1, 2);
    tick();
    in_valid = 0;
    checks++;
    if (iss_valid !== 1 || iss_rs1_data !== 0 || iss_rs2_data !== 0 || iss_rd !== 5'd3 || iss_opcode !== 7'b0110011) begin
      errors++; $display("FAIL first_issue: v=%b rs1=%h rs2=%h rd=%0d op=%b want 1/0/0/3/0110011", iss_valid, iss_rs1_data, iss_rs2_data, iss_rd, iss_opcode);
    end
    checks++;
    if (busy_mask !== 32'h8) begin errors++; $display("FAIL first_busy: got %h want 00000008", busy_mask); end
  endtask

  task automatic test_raw_stall();
    drive_wb(1, 32'd5);
    drive_wb(2, 32'd7);
    drive_wb(3, 32'd0);
    checks++;
    if (busy_mask !== 32'd0) begin errors++; $display("FAIL raw_busy_clear: got %h want 0", busy_mask); end
    in_valid = 1; in_instr = enc_add(3, 1, 2);
    tick();
    checks++;
    if (iss_rs1_data !== 32'd5 || iss_rs2_data !== 32'd7 || iss_rd !== 5'd3) begin
      errors++; $display("FAIL raw_operands: rs1=%0d rs2=%0d rd=%0d want 5/7/3", iss_rs1_data, iss_rs2_data, iss_rd);
    end
    in_instr = enc_add(4, 3, 3);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_%0d: in_ready=%b want 0", c, in_ready); end
      tick();
    end
    wb_en = 1; wb_addr = 3; wb_data = 32'd12;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release: in_ready=%b want 1", in_ready); end
    tick();
    wb_en = 0; in_valid = 0;
    checks++;
    if (iss_valid !== 1 || iss_rs1_data !== 32'd12 || iss_rs2_data !== 32'd12 || iss_rd !== 5'd4) begin
      errors++; $display("FAIL raw_bypass: v=%b rs1=%0d rs2=%0d rd=%0d want 1/12/12/4", iss_valid, iss_rs1_data, iss_rs2_data, iss_rd);
    end
    checks++;
    if (busy_mask !== 32'h10) begin errors++; $display("FAIL raw_busy: got %h want 00000010", busy_mask); end
  endtask

  task automatic test_back_to_back();
    drive_wb(4, 32'd0);
    iss_ready = 0; in_valid = 1; in_instr = enc_addi(7, 1, 12'd3);
    tick();
    in_instr = enc_addi(8, 2, 12'd4);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_%0d: in_ready=%b want 0", c, in_ready); end
      tick();
      checks++;
      if (iss_valid !== 1 || iss_rd !== 5'd7 || iss_rs1_data !== 32'd5 || iss_imm12 !== 12'd3) begin
        errors++; $display("FAIL hold_stable_%0d: v=%b rd=%0d rs1=%0d imm=%0d want 1/7/5/3", c, iss_valid, iss_rd, iss_rs1_data, iss_imm12);
      end
    end
    iss_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: in_ready=%b want 1", in_ready); end
    tick();
    in_valid = 0;
    checks++;
    if (iss_valid !== 1 || iss_rd !== 5'd8 || iss_rs1_data !== 32'd7) begin
      errors++; $display("FAIL b2b_second: v=%b rd=%0d rs1=%0d want 1/8/7", iss_valid, iss_rd, iss_rs1_data);
    end
    tick();
    checks++;
    if (iss_valid !== 1'b0 || busy_mask !== 32'h180) begin
      errors++; $display("FAIL b2b_drain: v=%b busy=%h want 0/00000180", iss_valid, busy_mask);
    end
  endtask

  task automatic test_x0();
    wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    in_valid = 1; in_instr = enc_add(5, 0, 0);
    tick();
    wb_en = 0;
    checks++;
    if (iss_rs1_data !== 0 || iss_rs2_data !== 0) begin
      errors++; $display("FAIL x0_no_forward: rs1=%h rs2=%h want 0/0", iss_rs1_data, iss_rs2_data);
    end
    in_instr = enc_add(9, 0, 0);
    tick();
    checks++;
    if (iss_rs1_data !== 0 || iss_rs2_data !== 0 || iss_rd !== 5'd9) begin
      errors++; $display("FAIL x0_read: rs1=%h rs2=%h rd=%0d want 0/0/9", iss_rs1_data, iss_rs2_data, iss_rd);
    end
    in_instr = enc_addi(0, 1, 12'd1);
    tick();
    in_valid = 0;
    checks++;
    if (iss_valid !== 1 || iss_rd !== 5'd0 || iss_rs1_data !== 32'd5 || busy_mask !== 32'h3A0) begin
      errors++; $display("FAIL x0_write: v=%b rd=%0d rs1=%0d busy=%h want 1/0/5/000003a0", iss_valid, iss_rd, iss_rs1_data, busy_mask);
    end
  endtask

  task automatic test_source_usage();
    clear_pending();
    in_valid = 1; in_instr = enc_addi(2, 0, 12'd9);
    tick();
    in_instr = enc_sw(1, 2, 12'd0);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL sw_stall_%0d: in_ready=%b want 0", c, in_ready); end
      tick();
    end
    wb_en = 1; wb_addr = 2; wb_data = 32'd77;
    tick();
    wb_en = 0;
    checks++;
    if (iss_valid !== 1 || iss_opcode !== 7'b0100011 || iss_rs1_data !== 32'd5 || iss_rs2_data !== 32'd77) begin
      errors++; $display("FAIL sw_issue: v=%b op=%b rs1=%0d rs2=%0d want 1/0100011/5/77", iss_valid, iss_opcode, iss_rs1_data, iss_rs2_data);
    end
    in_instr = enc_addi(1, 0, 12'd1);
    tick();
    in_instr = enc_lui(6, 20'hABCDE);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lui_ready: in_ready=%b want 1", in_ready); end
    tick();
    in_valid = 0;
    checks++;
    if (iss_valid !== 1 || iss_opcode !== 7'b0110111 || iss_rd !== 5'd6 || busy_mask !== 32'h42) begin
      errors++; $display("FAIL lui_issue: v=%b op=%b rd=%0d busy=%h want 1/0110111/6/00000042", iss_valid, iss_opcode, iss_rd, busy_mask);
    end
  endtask

  task automatic test_reset_midflight();
    clear_pending();
    drive_wb(1, 32'd99);
    in_valid = 1; in_instr = enc_addi(3, 1, 12'd1);
    tick();
    in_instr = enc_addi(4, 1, 12'd2);
    tick();
    iss_ready = 0; in_valid = 0;
    tick();
    checks++;
    if (iss_valid !== 1 || busy_mask !== 32'h18) begin
      errors++; $display("FAIL pre_reset: v=%b busy=%h want 1/00000018", iss_valid, busy_mask);
    end
    rst = 1; in_valid = 1; in_instr = enc_addi(5, 1, 12'd1);
    wb_en = 1; wb_addr = 3; wb_data = 32'd42;
    tick();
    rst = 0; in_valid = 0; wb_en = 0; iss_ready = 1;
    checks++;
    if (iss_valid !== 0 || busy_mask !== 32'd0) begin
      errors++; $display("FAIL mid_reset: v=%b busy=%h want 0/0", iss_valid, busy_mask);
    end
    drive_wb(4, 32'd55);
    in_valid = 1; in_instr = enc_add(10, 1, 4);
    tick();
    in_valid = 0;
    checks++;
    if (iss_rs1_data !== 32'd0 || iss_rs2_data !== 32'd55 || busy_mask !== 32'h400) begin
      errors++; $display("FAIL post_reset: rs1=%0d rs2=%0d busy=%h want 0/55/00000400", iss_rs1_data, iss_rs2_data, busy_mask);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    logic [31:0] ins;
    logic [95:0] exp_pkt;
    logic [95:0] got_pkt;
    bit held;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0100011; ops[3] = 7'b1100011;
    ops[4] = 7'b0110111; ops[5] = 7'b0010111; ops[6] = 7'b1101111; ops[7] = 7'b0000011;
    held = 0;
    for (int n = 0; n < 600; n++) begin
      if (!held) begin
        ins = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 7)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        in_instr = ins;
        in_valid = ($urandom_range(0, 3) != 0);
      end
      iss_ready = ($urandom_range(0, 3) != 0);
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      #1;
      checks++;
      if (in_ready !== m_ready()) begin
        errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b instr=%h", n, in_ready, m_ready(), in_instr);
      end
      held = in_valid && !m_ready();
      tick();
      exp_q.push_back({m_instr[6:0], m_instr[11:7], m_instr[14:12], m_instr[31:25], m_instr[31:20],
                       m_instr[24:20], m_op1, m_op2});
      exp_pkt = exp_q.pop_front();
      got_pkt = {iss_opcode, iss_rd, iss_funct3, iss_funct7, iss_imm12, iss_shamt, iss_rs1_data, iss_rs2_data};
      checks++;
      if (iss_valid !== m_valid || busy_mask !== m_pend) begin
        errors++; $display("FAIL rand_state[%0d]: v=%b busy=%h want %b/%h", n, iss_valid, busy_mask, m_valid, m_pend);
      end
      checks++;
      if (got_pkt !== exp_pkt) begin
        errors++; $display("FAIL rand_packet[%0d]: got %h want %h", n, got_pkt, exp_pkt);
      end
    end
    in_valid = 0; wb_en = 0; iss_ready = 1;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_instr = '0; iss_ready = 1;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    m_valid = 0; m_pend = '0;
    test_reset();
    test_raw_stall();
    test_back_to_back();
    test_x0();
    test_source_usage();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_issue.md
Name: regfile_issue

Overview:
- Parametrised successor to the single-port decode/register-select stage: one decode/issue stage in front of the ALU.
- Accepts 32-bit RISC-V instructions with a valid/ready handshake, decodes fields and reads the operands from an NREGS x XLEN register file.
- Tracks in-flight destinations with a scoreboard and forwards same-cycle writebacks.
- Presents one registered issue packet per instruction to the execute stage and takes ALU results back on a writeback port.

Parameters:
- XLEN, 32, data width of registers, operands and writeback.
- NREGS, 32, number of architectural registers; power of two, 2..32.
- AW, $clog2(NREGS), register address width; instruction field bits above AW are ignored.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_instr  in  32  RISC-V instruction word.
- in_ready  out  1  stage can accept in_instr this cycle.
- iss_valid  out  1  issue packet valid.
- iss_ready  in  1  execute stage accepts the packet.
- iss_opcode  out  7  instr[6:0].
- iss_rd  out  AW  instr[11:7].
- iss_funct3  out  3  instr[14:12].
- iss_funct7  out  7  instr[31:25].
- iss_imm12  out  12  instr[31:20].
- iss_shamt  out  5  instr[24:20].
- iss_rs1_data  out  XLEN  source 1 operand.
- iss_rs2_data  out  XLEN  source 2 operand.
- wb_en  in  1  writeback strobe.
- wb_addr  in  AW  writeback register.
- wb_data  in  XLEN  writeback value.
- busy_mask  out  NREGS  scoreboard pending bits, for debug.

Behaviour:
- Reset (synchronous): all registers 0, all pending bits 0, iss_valid 0, all iss_* fields 0.
  - Reset wins over simultaneous accept or writeback.
  - In-flight results arriving after reset are written normally.
- Register x0:
  - Reads return 0.
  - Writes are ignored.
  - Never pending; never forwarded.
- Source usage:
  - uses_rs1 = opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
  - uses_rs2 = opcode in {0110011, 0100011, 1100011}.
  - writes_rd = opcode not in {0100011, 1100011} and rd != 0.
- Hazard check:
  - A used source, or rd when writes_rd, is "blocked" if its pending bit is set.
  - Exception: wb_en is high this cycle with wb_addr equal to that register.
  - hazard = any blocked register.
- Handshake:
  - slot_free = !iss_valid | iss_ready.
  - in_ready = slot_free & !hazard.
  - in_ready is combinational from in_instr, scoreboard, wb_*, iss_ready.
  - Accept = in_valid & in_ready.
- On accept:
  - Fields and operands are registered into the issue packet; iss_valid = 1 next cycle (latency 1).
  - Operand = wb_data if wb_en & wb_addr == src & src != 0 (bypass); else the register-file value.
  - Unused sources are still read (no masking).
  - If writes_rd, pending[rd] is set next edge.
- Issue packet holding:
  - Held stable while iss_valid & !iss_ready.
  - Fires on iss_valid & iss_ready; iss_valid drops next cycle unless a new accept occurs the same cycle (back-to-back, 1 instr/clk).
- Writeback on wb_en & wb_addr != 0: reg[wb_addr] <= wb_data; pending[wb_addr] cleared.
- Same-edge writeback and accept setting the same rd: pending stays 1 (the set wins).
- WAW is impossible because a pending rd blocks issue. Writeback to a non-pending register is still written; no error.
- Throughput: no bubbles when no hazard. The hazard stall lasts until the matching wb_en cycle, in which the instruction is accepted with bypass.

Test Plan:
- Reset, then check: in_ready=1, iss_valid=0, busy_mask=0; issue ADD x3,x1,x2 -> iss_rs1_data=0, iss_rs2_data=0 next cycle, busy_mask=0x8.
- Preload x1=5, x2=7 via wb; issue ADD x3,x1,x2 -> operands 5 and 7, iss_rd=3; then ADD x4,x3,x3 -> in_ready=0 until wb_en(x3, 12) cycle, accepted that cycle with both operands=12.
- Hold iss_ready=0 for 3 cycles with in_valid=1 -> packet stable, in_ready=0; release -> two instructions issue on consecutive cycles.
- wb_en to x0 with 0xFFFF_FFFF -> later ADD x5,x0,x0 reads 0; ADDI x0,x1,1 -> busy_mask unchanged.
- SW x2,0(x1) with x2 pending -> stalls; LUI x6 with x1 pending -> accepted immediately.
- Assert rst with packet pending and busy_mask=0x18 -> next cycle iss_valid=0, busy_mask=0, x1 reads 0.
